wb_stage_regfile: RTL and testbench
===================================

Name: wb_stage_regfile

Overview:
- Consumer end of the MEM/WB pipeline register.
- Takes the registered MEM/WB bundle, formats load data by size and sign, and selects the writeback value from load, link, or R-form.
- Commits the value into the 32x32 general register file, which this block owns.
- Serves the two ID-stage read ports, with optional write-through bypass, and counts retired register writes.

Parameters:
- LINK_OFFSET, 8: value added to WB_PC to form the link (return) address.
- NREG, 32: number of architectural registers; register 0 is hardwired to zero.
- CNT_W, 32: width of the retired-write counter.

Ports:
- CLOCK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- WB_MEMTOREG  in  1  select formatted load data.
- WB_REGWRITE  in  1  register write enable.
- WB_SIZE  in  2  load size: 00 word, 01 half, 10 byte, 11 treated as word.
- WB_LWSIG  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
- WB_ADDRLO  in  2  low address bits of the load, used for lane selection.
- WB_lwans  in  32  raw memory read word.
- WB_PC  in  32  PC of the instruction.
- WB_Rform  in  32  ALU/R-form result.
- WB_linksig  in  1  link instruction; write PC+LINK_OFFSET.
- WB_wherereg  in  5  destination register index.
- RD_ADDR1  in  5  read port 1 index.
- RD_ADDR2  in  5  read port 2 index.
- RD_DATA1  out  32  read port 1 data.
- RD_DATA2  out  32  read port 2 data.
- WB_DATA  out  32  selected writeback value (combinational), for EX forwarding.
- WB_WEN  out  1  effective write this cycle: REGWRITE and wherereg != 0.
- RETIRE_CNT  out  CNT_W  count of committed register writes.

Behaviour:
- Reset (RESET=0, asynchronous): all registers cleared to 0 and RETIRE_CNT cleared to 0. RD_DATA* therefore read 0. WB_DATA and WB_WEN remain combinational from their inputs.
- Load formatting (little-endian lanes):
  - Byte: lane = WB_ADDRLO, i.e. bits [8*lane+7 : 8*lane].
  - Half: lane = WB_ADDRLO[1], i.e. bits [16*lane+15 : 16*lane]; WB_ADDRLO[0] is ignored.
  - Word: WB_lwans passed through unchanged.
  - Sub-word values are extended to 32 bits per WB_LWSIG.
- Select priority: WB_linksig → WB_PC+LINK_OFFSET (mod 2^32); else WB_MEMTOREG → formatted load; else WB_Rform.
- Commit: on the rising edge with WB_WEN=1, reg[WB_wherereg] <= WB_DATA. Writes to register 0 are dropped. Latency from MEM/WB output to architectural state is 1 edge.
- RETIRE_CNT increments by 1 on each edge with WB_WEN=1 and wraps from all-ones to 0.
- Reads are combinational. Index 0 always returns 0, including when a write to index 0 is presented.
- Simultaneous read and write of the same register: result depends on the optional feature.
- Reset asserted mid-write: reset wins; no write lands and the counter stays 0.
- Inputs must be stable around the edge; no handshake (the pipeline register guarantees this).

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: if WB_WEN=1 and RD_ADDRn == WB_wherereg (nonzero), RD_DATAn = WB_DATA in the same cycle, giving a write-before-read regfile. ID needs no extra stall for WB hazards.
- Undefined: RD_DATAn always returns the stored value, so the new value is visible only after the edge. The hazard unit must stall one extra cycle.

Decomposition:
- Shared package: SIZE encodings (SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10), REG_ZERO=5'd0, REG_RA=5'd31, data width 32, register index width 5.
- Sub-module wb_load_align: combinational lane select and extension; inputs lwans, size, lwsig, addrlo; output 32-bit value.
- Register array, select mux, bypass and counter live in the top.

Test Plan:
- Reset then read all 32 indices → every RD_DATA = 0 and RETIRE_CNT = 0. Write 0xDEADBEEF to r5, assert RESET mid-cycle → r5 reads 0.
- Byte load: lwans=0x80FF7F01, SIZE=10, ADDRLO=2.
  - LWSIG=1 → r8=0xFFFFFFFF.
  - ADDRLO=3, LWSIG=1 → 0xFFFFFF80.
  - ADDRLO=3, LWSIG=0 → 0x00000080.
- Half load: lwans=0x80FF7F01, SIZE=01, ADDRLO=2 → LWSIG=1 gives 0xFFFF80FF; LWSIG=0 gives 0x000080FF. ADDRLO=0 with LWSIG=1 gives 0x00007F01.
- Link priority: linksig=1, MEMTOREG=1, PC=0x00400010, wherereg=31 → r31=0x00400018. Separately, PC=0xFFFFFFFC → r31=0x00000004 (wrap).
- r0 protection: REGWRITE=1, wherereg=0, Rform=0x12345678 → WB_WEN=0, r0 reads 0, RETIRE_CNT unchanged. Three writes to r1..r3 → RETIRE_CNT=3.
- Bypass: write Rform=0xA5A5A5A5 to r7 with RD_ADDR1=7 in the same cycle.
  - With WB_REGFILE_BYPASS_EN: RD_DATA1=0xA5A5A5A5 before the edge.
  - Without: RD_DATA1 holds the old value until after the edge.

Source files
------------

// File: rtl/wb_stage_regfile_pkg.sv
// Shared definitions for the writeback stage: load-size encodings, register
// index constants and the datapath widths.
package wb_stage_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int RIDX_W = 5;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [RIDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [RIDX_W-1:0] REG_RA   = 5'd31;

  // Extend an 8- or 16-bit value held in the low bits of a word.
  function automatic logic [DATA_W-1:0] extend_sub(input logic [DATA_W-1:0] v,
                                                   input logic             is_half,
                                                   input logic             sgn);
    logic [DATA_W-1:0] r;
    if (is_half) r = {{16{sgn & v[15]}}, v[15:0]};
    else         r = {{24{sgn & v[7]}}, v[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/wb_stage_regfile_load_align.sv
// Load formatter: picks the little-endian byte/half lane addressed by the low
// address bits and sign- or zero-extends it; words pass straight through.
module wb_load_align
  import wb_stage_regfile_pkg::*;
(
  input  logic [DATA_W-1:0] lwans,
  input  logic [1:0]        size,
  input  logic              lwsig,
  input  logic [1:0]        addrlo,
  output logic [DATA_W-1:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (addrlo)
      2'd0:    byte_lane = lwans[7:0];
      2'd1:    byte_lane = lwans[15:8];
      2'd2:    byte_lane = lwans[23:16];
      default: byte_lane = lwans[31:24];
    endcase
  end

  // Half lane ignores addrlo[0]; misaligned halves are the pipeline's problem.
  assign half_lane = addrlo[1] ? lwans[31:16] : lwans[15:0];

  always_comb begin
    value = lwans;
    case (size)
      SZ_HALF: value = extend_sub({16'h0000, half_lane}, 1'b1, lwsig);
      SZ_BYTE: value = extend_sub({24'h000000, byte_lane}, 1'b0, lwsig);
      default: value = lwans;
    endcase
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// Writeback stage and architectural register file: selects link/load/R-form
// result, commits it, serves two ID read ports and counts retired writes.
// Build option: define WB_REGFILE_BYPASS_EN for write-through reads.
module wb_stage_regfile
  import wb_stage_regfile_pkg::*;
#(
  parameter int LINK_OFFSET = 8,
  parameter int NREG        = 32,
  parameter int CNT_W       = 32
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              WB_MEMTOREG,
  input  logic              WB_REGWRITE,
  input  logic [1:0]        WB_SIZE,
  input  logic              WB_LWSIG,
  input  logic [1:0]        WB_ADDRLO,
  input  logic [DATA_W-1:0] WB_lwans,
  input  logic [DATA_W-1:0] WB_PC,
  input  logic [DATA_W-1:0] WB_Rform,
  input  logic              WB_linksig,
  input  logic [RIDX_W-1:0] WB_wherereg,
  input  logic [RIDX_W-1:0] RD_ADDR1,
  input  logic [RIDX_W-1:0] RD_ADDR2,
  output logic [DATA_W-1:0] RD_DATA1,
  output logic [DATA_W-1:0] RD_DATA2,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              WB_WEN,
  output logic [CNT_W-1:0]  RETIRE_CNT
);

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] link_addr;
  logic [CNT_W-1:0]  retire_cnt;

  wb_load_align u_load_align (
    .lwans  (WB_lwans),
    .size   (WB_SIZE),
    .lwsig  (WB_LWSIG),
    .addrlo (WB_ADDRLO),
    .value  (load_val)
  );

  assign link_addr = WB_PC + DATA_W'(LINK_OFFSET);

  always_comb begin
    WB_DATA = WB_Rform;
    if (WB_linksig)       WB_DATA = link_addr;
    else if (WB_MEMTOREG) WB_DATA = load_val;
  end

  assign WB_WEN = WB_REGWRITE && (WB_wherereg != REG_ZERO);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      retire_cnt <= '0;
    end else if (WB_WEN) begin
      regs[WB_wherereg] <= WB_DATA;
      retire_cnt        <= retire_cnt + CNT_W'(1);
    end
  end

  assign RETIRE_CNT = retire_cnt;

  // Index 0 is forced to zero at the port regardless of what storage holds.
  always_comb begin
    RD_DATA1 = '0;
    RD_DATA2 = '0;
    if (RD_ADDR1 != REG_ZERO) RD_DATA1 = regs[RD_ADDR1];
    if (RD_ADDR2 != REG_ZERO) RD_DATA2 = regs[RD_ADDR2];
`ifdef WB_REGFILE_BYPASS_EN
    if (WB_WEN && (RD_ADDR1 == WB_wherereg)) RD_DATA1 = WB_DATA;
    if (WB_WEN && (RD_ADDR2 == WB_wherereg)) RD_DATA2 = WB_DATA;
`endif
  end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Bench for wb_stage_regfile: directed cases plus randomized writeback traffic
// checked against an array/arithmetic model of the register file.
module tb_wb_stage_regfile;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        WB_MEMTOREG, WB_REGWRITE, WB_LWSIG, WB_linksig;
  logic [1:0]  WB_SIZE, WB_ADDRLO;
  logic [31:0] WB_lwans, WB_PC, WB_Rform;
  logic [4:0]  WB_wherereg, RD_ADDR1, RD_ADDR2;
  logic [31:0] RD_DATA1, RD_DATA2, WB_DATA;
  logic        WB_WEN;
  logic [31:0] RETIRE_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_regs [32];
  logic [31:0] model_cnt;

  always #5 CLOCK = ~CLOCK;

  wb_stage_regfile dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .WB_MEMTOREG (WB_MEMTOREG),
    .WB_REGWRITE (WB_REGWRITE),
    .WB_SIZE     (WB_SIZE),
    .WB_LWSIG    (WB_LWSIG),
    .WB_ADDRLO   (WB_ADDRLO),
    .WB_lwans    (WB_lwans),
    .WB_PC       (WB_PC),
    .WB_Rform    (WB_Rform),
    .WB_linksig  (WB_linksig),
    .WB_wherereg (WB_wherereg),
    .RD_ADDR1    (RD_ADDR1),
    .RD_ADDR2    (RD_ADDR2),
    .RD_DATA1    (RD_DATA1),
    .RD_DATA2    (RD_DATA2),
    .WB_DATA     (WB_DATA),
    .WB_WEN      (WB_WEN),
    .RETIRE_CNT  (RETIRE_CNT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Writeback value straight from the selection and lane rules.
  function automatic logic [31:0] ref_wb();
    logic [31:0] v;
    if (WB_linksig)   return WB_PC + 32'd8;
    if (!WB_MEMTOREG) return WB_Rform;
    if (WB_SIZE == 2'b10) begin
      v = (WB_lwans >> (8 * WB_ADDRLO)) & 32'hFF;
      if (WB_LWSIG && v >= 32'h80) v = v + 32'hFFFFFF00;
      return v;
    end
    if (WB_SIZE == 2'b01) begin
      v = (WB_lwans >> (16 * (WB_ADDRLO / 2))) & 32'hFFFF;
      if (WB_LWSIG && v >= 32'h8000) v = v + 32'hFFFF0000;
      return v;
    end
    return WB_lwans;
  endfunction

  function automatic logic ref_wen();
    return WB_REGWRITE && (WB_wherereg != 0);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
    if (ref_wen() && a == WB_wherereg) return ref_wb();
`endif
    return model_regs[a];
  endfunction

  task automatic set_idle();
    WB_MEMTOREG = 0; WB_REGWRITE = 0; WB_SIZE = 0; WB_LWSIG = 0; WB_ADDRLO = 0;
    WB_lwans = 0; WB_PC = 0; WB_Rform = 0; WB_linksig = 0; WB_wherereg = 0;
  endtask

  task automatic set_wr(input logic [4:0] rd, input logic [31:0] val);
    set_idle();
    WB_REGWRITE = 1; WB_wherereg = rd; WB_Rform = val;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [1:0] sz,
                          input logic [1:0] lo, input logic sgn, input logic [31:0] word);
    set_idle();
    WB_REGWRITE = 1; WB_MEMTOREG = 1; WB_wherereg = rd;
    WB_SIZE = sz; WB_ADDRLO = lo; WB_LWSIG = sgn; WB_lwans = word;
  endtask

  // Inputs are set after a negedge; check combinational outputs, take the edge,
  // update the model, and return at the following negedge.
  task automatic cycle();
    logic [31:0] d;
    logic        w;
    #1;
    d = ref_wb();
    w = ref_wen();
    check("wb_data", WB_DATA, d);
    check("wb_wen", {31'b0, WB_WEN}, {31'b0, w});
    check("rd_data1", RD_DATA1, ref_rd(RD_ADDR1));
    check("rd_data2", RD_DATA2, ref_rd(RD_ADDR2));
    check("retire_cnt", RETIRE_CNT, model_cnt);
    @(posedge CLOCK);
    if (w) begin
      model_regs[WB_wherereg] = d;
      model_cnt = model_cnt + 1;
    end
    @(negedge CLOCK);
  endtask

  // Read a register after the write has landed, against a fixed value.
  task automatic read_back(input string tag, input logic [4:0] a, input logic [31:0] exp);
    set_idle();
    RD_ADDR1 = a;
    #1;
    check(tag, RD_DATA1, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 32'h0;
  endtask

  initial begin
    logic [31:0] cnt_before;
    RESET = 0;
    set_idle();
    RD_ADDR1 = 0; RD_ADDR2 = 0;
    model_reset();
    repeat (2) @(negedge CLOCK);

    for (int i = 0; i < 32; i++) begin
      RD_ADDR1 = 5'(i);
      RD_ADDR2 = 5'(31 - i);
      #1;
      check("reset_rd1", RD_DATA1, 32'h0);
      check("reset_rd2", RD_DATA2, 32'h0);
    end
    check("reset_cnt", RETIRE_CNT, 32'h0);
    @(negedge CLOCK);
    RESET = 1;
    @(negedge CLOCK);

    // Reset asserted while a write to r5 is presented.
    set_wr(5'd5, 32'hDEADBEEF);
    #2 RESET = 0;
    @(posedge CLOCK);
    model_reset();
    @(negedge CLOCK);
    RESET = 1;
    read_back("midreset_r5", 5'd5, 32'h0);
    check("midreset_cnt", RETIRE_CNT, 32'h0);
    @(negedge CLOCK);

    cnt_before = model_cnt;
    set_wr(5'd0, 32'h12345678); RD_ADDR1 = 0; cycle();
    read_back("r0_read", 5'd0, 32'h0);
    check("r0_cnt", RETIRE_CNT, cnt_before);
    set_wr(5'd1, 32'h1); cycle();
    set_wr(5'd2, 32'h2); cycle();
    set_wr(5'd3, 32'h3); cycle();
    check("cnt_three", RETIRE_CNT, 32'd3);

    set_load(5'd8, 2'b10, 2'd2, 1'b1, 32'h80FF7F01); RD_ADDR1 = 8; cycle();
    read_back("byte_lo2_s", 5'd8, 32'hFFFFFFFF);
    set_load(5'd8, 2'b10, 2'd3, 1'b1, 32'h80FF7F01); cycle();
    read_back("byte_lo3_s", 5'd8, 32'hFFFFFF80);
    set_load(5'd8, 2'b10, 2'd3, 1'b0, 32'h80FF7F01); cycle();
    read_back("byte_lo3_u", 5'd8, 32'h00000080);
    set_load(5'd9, 2'b01, 2'd2, 1'b1, 32'h80FF7F01); cycle();
    read_back("half_lo2_s", 5'd9, 32'hFFFF80FF);
    set_load(5'd9, 2'b01, 2'd2, 1'b0, 32'h80FF7F01); cycle();
    read_back("half_lo2_u", 5'd9, 32'h000080FF);
    set_load(5'd9, 2'b01, 2'd0, 1'b1, 32'h80FF7F01); cycle();
    read_back("half_lo0_s", 5'd9, 32'h00007F01);

    set_load(5'd31, 2'b00, 2'd0, 1'b0, 32'h55AA55AA);
    WB_linksig = 1; WB_PC = 32'h00400010; cycle();
    read_back("link_pc", 5'd31, 32'h00400018);
    set_wr(5'd31, 32'h0); WB_linksig = 1; WB_PC = 32'hFFFFFFFC; cycle();
    read_back("link_wrap", 5'd31, 32'h00000004);

    set_wr(5'd7, 32'h11111111); cycle();
    set_wr(5'd7, 32'hA5A5A5A5); RD_ADDR1 = 7;
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("bypass_pre", RD_DATA1, 32'hA5A5A5A5);
`else
    check("bypass_pre", RD_DATA1, 32'h11111111);
`endif
    cycle();
    read_back("bypass_post", 5'd7, 32'hA5A5A5A5);

    for (int n = 0; n < 400; n++) begin
      WB_MEMTOREG = 1'($urandom_range(0, 1));
      WB_REGWRITE = ($urandom_range(0, 3) != 0);
      WB_SIZE     = 2'($urandom_range(0, 3));
      WB_LWSIG    = 1'($urandom_range(0, 1));
      WB_ADDRLO   = 2'($urandom_range(0, 3));
      WB_lwans    = $urandom;
      WB_PC       = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      WB_Rform    = $urandom;
      WB_linksig  = ($urandom_range(0, 5) == 0);
      WB_wherereg = 5'($urandom_range(0, 31));
      RD_ADDR1    = ($urandom_range(0, 3) == 0) ? WB_wherereg : 5'($urandom_range(0, 31));
      RD_ADDR2    = ($urandom_range(0, 3) == 0) ? WB_wherereg : 5'($urandom_range(0, 31));
      cycle();
    end

    set_idle();
    for (int i = 0; i < 32; i++) begin
      RD_ADDR1 = 5'(i);
      #1;
      check("final_rd", RD_DATA1, (i == 0) ? 32'h0 : model_regs[i]);
    end
    check("final_cnt", RETIRE_CNT, model_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
